// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the BCD down counter: FSM state encoding and
// per-digit constants used by both the top level and the digit decrementer.
package bcd_counter_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Legacy-compatible state codes, wrapped in an enum for readability.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: subtract borrow_in, wrapping 0 -> 9
// and producing a borrow for the next more significant digit.
module bcd_digit_dec
    import bcd_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               borrow_out
);

    // Decrement one digit when a borrow arrives from below.
    always_comb begin
        digit_next = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                digit_next = DIGIT_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with IDLE/RUN/DONE control FSM.
// Loads are validated (every nibble must be 0..9); rejected loads pulse err.
// Optional auto-reload from DONE is enabled by defining
// BCD_DOWN_COUNTER_RELOAD_EN; without it the reload register is not built.
module bcd_down_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    state_t                 state;
    logic [NUM_DIGITS:0]    borrow;
    logic [W-1:0]           count_dec;
    logic [NUM_DIGITS-1:0]  nib_ok;
    logic                   load_ok;
    logic                   load_zero;
    logic                   dec_zero;
    logic                   underflow;

    // LSD always takes a borrow: the chain computes count - 1.
    assign borrow[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            bcd_digit_dec u_dig (
                .digit      (count[g*DIGIT_W +: DIGIT_W]),
                .borrow_in  (borrow[g]),
                .digit_next (count_dec[g*DIGIT_W +: DIGIT_W]),
                .borrow_out (borrow[g+1])
            );
            assign nib_ok[g] = (load_val[g*DIGIT_W +: DIGIT_W] <= DIGIT_MAX);
        end
    endgenerate

    assign load_ok   = &nib_ok;
    assign load_zero = (load_val == '0);
    assign dec_zero  = (count_dec == '0);
    // A borrow out of the MSD means count was already 0; never wrap below it.
    assign underflow = borrow[NUM_DIGITS];

    assign busy = (state == RUN);

`ifdef BCD_DOWN_COUNTER_RELOAD_EN
    logic [W-1:0] reload;

    // Capture every valid nonzero load as the auto-reload value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            reload <= '0;
        else if (load && load_ok && !load_zero)
            reload <= load_val;
    end
`endif

    // Control FSM, count register and single-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                if (!load_ok) begin
                    err <= 1'b1;
                end else if (load_zero) begin
                    count <= '0;
                    state <= IDLE;
                end else begin
                    count <= load_val;
                    state <= RUN;
                end
            end else if (en) begin
                case (state)
                    RUN: begin
                        if (!underflow) begin
                            count <= count_dec;
                            if (dec_zero) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
                    DONE: begin
                        count <= reload;
                        state <= RUN;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: a decimal reference model pushes
// the expected {count,busy,done,err} for each cycle into a queue; each test
// pops and compares after the clock edge.
module tb_bcd_down_counter;

    localparam int ND = 2;
    localparam int W  = 4 * ND;
    localparam int EW = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         busy, done, err;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] sb[$];

    // Reference model state (decimal value, 0=IDLE 1=RUN 2=DONE).
    int m_val = 0;
    int m_st  = 0;
    int m_rel = 0;

    bcd_down_counter #(.NUM_DIGITS(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic int to_int(input logic [W-1:0] b);
        int r = 0;
        for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic is_valid(input logic [W-1:0] b);
        for (int i = 0; i < ND; i++) if (b[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle of stimulus, push the modelled result, wait for the edge.
    task automatic drive(input logic ld, input logic e, input logic [W-1:0] v);
        logic m_done = 1'b0;
        logic m_err  = 1'b0;
        @(negedge clk);
        load = ld; en = e; load_val = v;
        if (ld) begin
            if (!is_valid(v)) m_err = 1'b1;
            else if (to_int(v) == 0) begin m_val = 0; m_st = 0; end
            else begin m_val = to_int(v); m_rel = m_val; m_st = 1; end
        end else if (e) begin
            if (m_st == 1) begin
                m_val = m_val - 1;
                if (m_val == 0) begin m_st = 2; m_done = 1'b1; end
            end
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
            else if (m_st == 2) begin m_val = m_rel; m_st = 1; end
`endif
        end
        sb.push_back({to_bcd(m_val), m_st == 1, m_done, m_err});
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_val = 0; m_st = 0; m_rel = 0;
    endtask

    task automatic test_reset();
        logic [EW-1:0] got;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            got = {count, busy, done, err};
            total++;
            if (got !== '0) begin
                bad++;
                $display("FAIL reset: got %h want %h", got, {EW{1'b0}});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Stays idle with en high and no load.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, '0);
            got = {count, busy, done, err};
            total++;
            if (got !== sb.pop_front()) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got %h", i, got);
            end
        end
    endtask

    task automatic test_countdown();
        logic [EW-1:0] got, x;
        int ndone = 0;
        drive(1'b1, 1'b1, 8'h23);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL countdown_load: got %h want %h", got, x); end
        for (int i = 1; i <= 24; i++) begin
            drive(1'b0, 1'b1, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL countdown[%0d]: got %h want %h", i, got, x); end
            if (done === 1'b1) begin
                ndone++;
                total++;
                if (i != 23) begin bad++; $display("FAIL done_cycle: got %0d want 23", i); end
            end
        end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_invalid_load();
        logic [EW-1:0] got, x;
        logic [W-1:0] v [5] = '{8'h1A, 8'h00, 8'h15, 8'hA3, 8'hFF};
        logic ld [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(ld[i], 1'b1, v[i]);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL invalid_load[%0d]: got %h want %h", i, got, x); end
        end
        // Back-to-back rejected loads pulse err on consecutive cycles.
        drive(1'b0, 1'b0, '0);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL invalid_tail: got %h want %h", got, x); end
    endtask

    task automatic test_hold_and_priority();
        logic [EW-1:0] got, x;
        drive(1'b1, 1'b0, 8'h10);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL hold_load: got %h want %h", got, x); end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) void'(sb.pop_front());
        total++;
        if (count !== 8'h07) begin bad++; $display("FAIL hold_run3: got %h want 07", count); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL hold[%0d]: got %h want %h", i, got, x); end
        end
        drive(1'b1, 1'b1, 8'h05);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL load_priority: got %h want %h", got, x); end
        drive(1'b0, 1'b1, '0);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL after_priority: got %h want %h", got, x); end
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] got, x;
        drive(1'b1, 1'b1, 8'h40);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL pre_reset[%0d]: got %h want %h", i, got, x); end
        end
        #2;
        rst = 1'b1;
        #1;
        got = {count, busy, done, err}; total++;
        if (got !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", got); end
        repeat (2) begin
            @(posedge clk); #1;
            got = {count, busy, done, err}; total++;
            if (got !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", got); end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL post_reset[%0d]: got %h want %h", i, got, x); end
        end
    endtask

    task automatic test_zero_load();
        logic [EW-1:0] got, x;
        drive(1'b1, 1'b0, 8'h12);
        void'(sb.pop_front());
        drive(1'b1, 1'b1, 8'h00);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL zero_load: got %h want %h", got, x); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL zero_hold[%0d]: got %h want %h", i, got, x); end
        end
    endtask

    task automatic test_reload();
        logic [EW-1:0] got, x;
        drive(1'b1, 1'b1, 8'h02);
        x = sb.pop_front(); got = {count, busy, done, err}; total++;
        if (got !== x) begin bad++; $display("FAIL reload_load: got %h want %h", got, x); end
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, '0);
            x = sb.pop_front(); got = {count, busy, done, err}; total++;
            if (got !== x) begin bad++; $display("FAIL reload[%0d]: got %h want %h", i, got, x); end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_invalid_load();
        test_hold_and_priority();
        test_async_reset();
        test_zero_load();
        test_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of BCD digits; count width is 4*NUM_DIGITS.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; one decrement per enabled cycle while in RUN.
REQ-005 load  input  1  load strobe for load_val; has priority over en.
REQ-006 load_val  input  4*NUM_DIGITS  BCD start value, most significant digit in the top nibble.
REQ-007 count  output  4*NUM_DIGITS  current BCD value, registered.
REQ-008 busy  output  1  high while in state RUN.
REQ-009 done  output  1  single-cycle pulse when count reaches zero from RUN.
REQ-010 err  output  1  single-cycle pulse when a load is rejected.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 A load whose value has any nibble greater than 9 SHALL be rejected: err pulses on the next cycle, and count and state are unchanged.
REQ-013 A valid nonzero load, in any state, SHALL set count to load_val, store it in an internal reload register, and go to RUN on the next edge.
REQ-014 A valid zero load SHALL set count to all zeros and go to IDLE, with no done pulse.
REQ-015 In RUN with en=1 and load=0, count SHALL decrement by one in BCD: a digit at 0 wraps to 9 and borrows from the next digit.
REQ-016 In RUN, en=0 SHALL hold count and state.
REQ-017 A decrement from value 1 to 0 SHALL move the FSM to DONE and assert done in the same cycle that count first shows 0.
REQ-018 In IDLE and DONE without load, count SHALL hold; en is ignored, and count never wraps below 0.
REQ-019 Simultaneous load and en SHALL perform the load only.
REQ-020 The done and err outputs SHALL be registered and never high for two consecutive cycles unless triggered by two separate events.

Reset
REQ-021 Asserting rst SHALL immediately drive count=0, busy=0, done=0 and err=0, clear the reload register, and set the state to IDLE.
REQ-022 Reset asserted mid-RUN SHALL abort the countdown with no done pulse.
REQ-023 After rst deasserts, the block SHALL stay in IDLE until a valid load.

Configuration
REQ-024 The macro BCD_DOWN_COUNTER_RELOAD_EN SHALL control auto-reload.
REQ-025 With BCD_DOWN_COUNTER_RELOAD_EN defined: in DONE with en=1, count SHALL reload from the reload register and the FSM SHALL return to RUN on that edge.
REQ-026 Without BCD_DOWN_COUNTER_RELOAD_EN: DONE SHALL be exited only by load or rst, and the reload register logic is not synthesised.

Structure
REQ-027 Shared package bcd_counter_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), the digit width constant (4) and the maximum digit constant (9).
REQ-028 The sub-module bcd_digit_dec SHALL implement one digit: inputs are digit and borrow_in; outputs are next digit and borrow_out.
REQ-029 The top level SHALL chain NUM_DIGITS instances of bcd_digit_dec and own the FSM and the validity check.

Verification
REQ-030 Reset then load 0x23, en=1: count steps 23, 22, 21, 20, 19 ... 01, 00; done pulses exactly once, 23 cycles after load; busy then falls.
REQ-031 Load 0x1A: err pulses once; count stays at its prior value and the state is unchanged.
REQ-032 Load 0x10, run 3 cycles (count 07), en=0 for 5 cycles: count holds 07; load 0x05 with en=1 in the same cycle: next count 05, no decrement.
REQ-033 Load 0x40, run 10 cycles, assert rst asynchronously mid-cycle: count=00 and busy=0 immediately; no done pulse.
REQ-034 Load 0x00: count 00, state IDLE, done stays 0; en=1 for 5 cycles: count stays 00.
REQ-035 With BCD_DOWN_COUNTER_RELOAD_EN defined, load 0x02, en=1: count 02, 01, 00 (done), 02, 01, 00 (done); without the macro, count stays 00 after the first done.
